// File: rtl/nn_pkg.sv
// Shared types and helpers for the serial perceptron neuron.
package nn_pkg;

   // Controller states of the perceptron datapath.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_RESULT = 2'd2,
      ST_UPDATE = 2'd3
   } state_t;

   // Widest operand accepted by sat_add; callers size their values into it.
   localparam int SAT_MAX_W = 32;

   // Bits needed to address n_entries locations, never less than one.
   function automatic int addr_width(input int n_entries);
      int w;
      w = $clog2(n_entries);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

   // Signed add clamped to the range of a 'width'-bit two's complement value.
   function automatic logic signed [SAT_MAX_W-1:0] sat_add(
      input logic signed [SAT_MAX_W-1:0] a,
      input logic signed [SAT_MAX_W-1:0] b,
      input int                          width
   );
      longint sum;
      longint hi;
      longint lo;
      sum = longint'(a) + longint'(b);
      hi  = (longint'(1) <<< (width - 1)) - 1;
      lo  = -hi - 1;
      if (sum > hi) begin
         sum = hi;
      end else if (sum < lo) begin
         sum = lo;
      end
      return SAT_MAX_W'(sum);
   endfunction

endpackage

// File: rtl/nn_weight_regfile.sv
// Weight and bias storage: N_ENTRIES signed registers cleared on reset, a
// host write port, an internal update port, a combinational read port for
// the datapath and a registered read port for the host.
module nn_weight_regfile
   import nn_pkg::*;
#(
   parameter int N_ENTRIES = 21,
   parameter int W_WIDTH   = 8,
   parameter int AW        = addr_width(N_ENTRIES)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_we,
   input  logic [AW-1:0]             i_waddr,
   input  logic signed [W_WIDTH-1:0] i_wdata,
   input  logic                      i_upd_we,
   input  logic [AW-1:0]             i_upd_addr,
   input  logic signed [W_WIDTH-1:0] i_upd_data,
   input  logic [AW-1:0]             i_caddr,
   output logic signed [W_WIDTH-1:0] o_cdata,
   input  logic [AW-1:0]             i_raddr,
   output logic signed [W_WIDTH-1:0] o_rdata,
   output logic signed [W_WIDTH-1:0] o_last
);

   logic signed [W_WIDTH-1:0] r_mem [N_ENTRIES];
   logic signed [W_WIDTH-1:0] r_rdata;

   // Storage update; the internal update port wins over a host write.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
         if (rst) begin
            r_mem[i] <= '0;
         end else if (i_upd_we && (i_upd_addr == AW'(i))) begin
            r_mem[i] <= i_upd_data;
         end else if (i_we && (i_waddr == AW'(i))) begin
            r_mem[i] <= i_wdata;
         end
      end
   end

   // Host readback, one cycle latency; unmapped addresses read zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= '0;
         for (int i = 0; i < N_ENTRIES; i++) begin
            if (i_raddr == AW'(i)) begin
               r_rdata <= r_mem[i];
            end
         end
      end
   end

   // Datapath read of the entry currently being processed.
   always_comb begin
      o_cdata = '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         if (i_caddr == AW'(i)) begin
            o_cdata = r_mem[i];
         end
      end
   end

   assign o_rdata = r_rdata;
   assign o_last  = r_mem[N_ENTRIES-1];

endmodule

// File: rtl/perceptron_serial.sv
// Single perceptron neuron: serial multiply-accumulate over binary features,
// signed score plus (score > 0) prediction, optional perceptron-rule training.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is combinational (state == IDLE). out_valid is registered,
// and out_score/out_predict hold steady while out_valid is high until the
// edge where out_ready is also high.
module perceptron_serial
   import nn_pkg::*;
#(
   parameter int N_INPUTS  = 20,
   parameter int W_WIDTH   = 8,
   parameter int ACC_WIDTH = 16,
   parameter int LR        = 1,
   localparam int AW       = addr_width(N_INPUTS + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N_INPUTS-1:0]         in_x,
   input  logic                        in_train,
   input  logic                        in_label,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [ACC_WIDTH-1:0] out_score,
   output logic                        out_predict,
   input  logic                        w_we,
   input  logic [AW-1:0]               w_addr,
   input  logic signed [W_WIDTH-1:0]   w_wdata,
   output logic signed [W_WIDTH-1:0]   w_rdata,
   output logic                        busy
);

   generate
      if (ACC_WIDTH < W_WIDTH + $clog2(N_INPUTS + 1)) begin : g_acc_width_check
         $error("perceptron_serial: ACC_WIDTH too small for N_INPUTS and W_WIDTH");
      end
   endgenerate

   state_t                      r_state;
   logic [N_INPUTS-1:0]         r_x;
   logic                        r_train;
   logic                        r_label;
   logic signed [ACC_WIDTH-1:0] r_acc;
   logic signed [ACC_WIDTH-1:0] r_score;
   logic                        r_predict;
   logic                        r_out_valid;
   logic [AW-1:0]               r_idx;

   logic [2**AW-1:0]            w_xpad;
   logic                        w_x_bit;
   logic signed [W_WIDTH-1:0]   w_cdata;
   logic signed [W_WIDTH-1:0]   w_bias;
   logic signed [W_WIDTH-1:0]   w_bias_eff;
   logic signed [ACC_WIDTH-1:0] w_term;
   logic signed [ACC_WIDTH-1:0] w_acc_next;
   logic                        w_last_feat;
   logic                        w_upd_last;
   logic                        w_user_we;
   logic signed [W_WIDTH-1:0]   w_step;
   logic signed [W_WIDTH-1:0]   w_upd_val;
   logic                        w_upd_we;

   // Feature vector padded to the index range so r_idx selects it cleanly;
   // the pad bit at index N_INPUTS stands for the bias slot.
   assign w_xpad      = {{(2**AW - N_INPUTS){1'b0}}, r_x};
   assign w_x_bit     = w_xpad[r_idx];
   assign w_last_feat = (r_idx == AW'(N_INPUTS - 1));
   assign w_upd_last  = (r_idx == AW'(N_INPUTS));

   // Host writes land only while idle and only at mapped addresses.
   assign w_user_we   = w_we && (r_state == ST_IDLE) && (w_addr <= AW'(N_INPUTS));

   // A bias write in the accept cycle is forwarded so the pass uses it.
   assign w_bias_eff  = (w_user_we && (w_addr == AW'(N_INPUTS))) ? w_wdata : w_bias;

   assign w_term      = w_x_bit ? ACC_WIDTH'(w_cdata) : '0;
   assign w_acc_next  = r_acc + w_term;

   assign w_step      = r_label ? W_WIDTH'(LR) : W_WIDTH'(-LR);
   assign w_upd_val   = W_WIDTH'(sat_add(SAT_MAX_W'(w_cdata), SAT_MAX_W'(w_step), W_WIDTH));
   assign w_upd_we    = (r_state == ST_UPDATE) && (w_upd_last || w_x_bit);

   nn_weight_regfile #(
      .N_ENTRIES (N_INPUTS + 1),
      .W_WIDTH   (W_WIDTH),
      .AW        (AW)
   ) u_regfile (
      .clk        (clk),
      .rst        (rst),
      .i_we       (w_user_we),
      .i_waddr    (w_addr),
      .i_wdata    (w_wdata),
      .i_upd_we   (w_upd_we),
      .i_upd_addr (r_idx),
      .i_upd_data (w_upd_val),
      .i_caddr    (r_idx),
      .o_cdata    (w_cdata),
      .i_raddr    (w_addr),
      .o_rdata    (w_rdata),
      .o_last     (w_bias)
   );

   // Controller and MAC: accept, accumulate, present result, optional update.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_x         <= '0;
         r_train     <= 1'b0;
         r_label     <= 1'b0;
         r_acc       <= '0;
         r_idx       <= '0;
         r_score     <= '0;
         r_predict   <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_x     <= in_x;
                  r_train <= in_train;
                  r_label <= in_label;
                  r_acc   <= ACC_WIDTH'(w_bias_eff);
                  r_idx   <= '0;
                  r_state <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               r_acc <= w_acc_next;
               r_idx <= r_idx + AW'(1);
               if (w_last_feat) begin
                  r_score     <= w_acc_next;
                  r_predict   <= !w_acc_next[ACC_WIDTH-1] && (w_acc_next != '0);
                  r_out_valid <= 1'b1;
                  r_state     <= ST_RESULT;
               end
            end
            ST_RESULT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  if (r_train && (r_predict != r_label)) begin
                     r_idx   <= '0;
                     r_state <= ST_UPDATE;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            ST_UPDATE: begin
               r_idx <= r_idx + AW'(1);
               if (w_upd_last) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = (r_state == ST_IDLE);
   assign busy        = (r_state != ST_IDLE);
   assign out_valid   = r_out_valid;
   assign out_score   = r_score;
   assign out_predict = r_predict;

endmodule

// File: tb/tb_perceptron_serial.sv
// Self-checking bench for perceptron_serial (N_INPUTS=4, W_WIDTH=8).
module tb_perceptron_serial;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int ACC = 16;
   localparam int LR  = 1;
   localparam int AW  = 3;

   logic                  clk;
   logic                  rst;
   logic                  in_valid;
   logic                  in_ready;
   logic [N-1:0]          in_x;
   logic                  in_train;
   logic                  in_label;
   logic                  out_valid;
   logic                  out_ready;
   logic signed [ACC-1:0] out_score;
   logic                  out_predict;
   logic                  w_we;
   logic [AW-1:0]         w_addr;
   logic signed [W-1:0]   w_wdata;
   logic signed [W-1:0]   w_rdata;
   logic                  busy;

   int n_checks;
   int n_fail;

   // Reference weights: index N is the bias.
   int m_w [0:N];

   perceptron_serial #(
      .N_INPUTS  (N),
      .W_WIDTH   (W),
      .ACC_WIDTH (ACC),
      .LR        (LR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_x        (in_x),
      .in_train    (in_train),
      .in_label    (in_label),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_score   (out_score),
      .out_predict (out_predict),
      .w_we        (w_we),
      .w_addr      (w_addr),
      .w_wdata     (w_wdata),
      .w_rdata     (w_rdata),
      .busy        (busy)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic int sat_w(input int v);
      int hi;
      int lo;
      hi = (1 << (W - 1)) - 1;
      lo = -(1 << (W - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Score = bias + sum of weights whose feature bit is set; trains on mismatch.
   function automatic void model_run(input logic [N-1:0] x, input logic tr, input logic lb,
                                     output int es, output logic ep, output int eu);
      int d;
      es = m_w[N];
      for (int i = 0; i < N; i++) begin
         if (x[i]) es += m_w[i];
      end
      ep = (es > 0);
      eu = 0;
      if (tr && (ep != lb)) begin
         d = lb ? LR : -LR;
         for (int i = 0; i < N; i++) begin
            if (x[i]) m_w[i] = sat_w(m_w[i] + d);
         end
         m_w[N] = sat_w(m_w[N] + d);
         eu = N + 1;
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_w(input int addr, input int data);
      w_we    = 1'b1;
      w_addr  = AW'(addr);
      w_wdata = W'(data);
      step();
      w_we    = 1'b0;
      if (addr <= N) m_w[addr] = sat_w(data);
   endtask

   task automatic read_w(input int addr, output int data);
      w_addr = AW'(addr);
      step();
      data = int'(w_rdata);
   endtask

   // Sends one vector (optionally with a same-cycle weight write), waits for
   // the result, accepts it at once and then waits for busy to drop.
   task automatic run_vec(input logic [N-1:0] x, input logic tr, input logic lb,
                          input logic race_we, input int race_addr, input int race_data,
                          output logic signed [ACC-1:0] sc, output logic pr,
                          output int lat, output int upd, output logic rdy);
      rdy      = in_ready;
      in_valid = 1'b1;
      in_x     = x;
      in_train = tr;
      in_label = lb;
      w_we     = race_we;
      w_addr   = AW'(race_addr);
      w_wdata  = W'(race_data);
      step();
      in_valid = 1'b0;
      w_we     = 1'b0;
      lat = -1;
      for (int k = 1; k <= 50; k++) begin
         step();
         if (out_valid) begin
            lat = k;
            break;
         end
      end
      sc = out_score;
      pr = out_predict;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      upd = 0;
      while (busy && upd < 50) begin
         step();
         upd++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i <= N; i++) m_w[i] = 0;
      n_checks += 6;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      if (out_score !== 16'sd0) begin n_fail++; $display("FAIL reset_score got=%0d want=0", out_score); end
      if (out_predict !== 1'b0) begin n_fail++; $display("FAIL reset_predict got=%b want=0", out_predict); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
      if (w_rdata !== 8'sd0) begin n_fail++; $display("FAIL reset_rdata got=%0d want=0", w_rdata); end
   endtask

   task automatic test_basic();
      logic [N-1:0]          tx [3];
      int                    es [3];
      logic                  ep [3];
      logic signed [ACC-1:0] sc;
      logic                  pr;
      logic                  rdy;
      int                    lat;
      int                    upd;
      tx = '{4'b0001, 4'b0110, 4'b1000};
      es = '{2, -4, 0};
      ep = '{1'b1, 1'b0, 1'b0};
      write_w(0, 2);
      write_w(1, -2);
      write_w(2, -2);
      write_w(3, 0);
      write_w(4, 0);
      for (int t = 0; t < 3; t++) begin
         run_vec(tx[t], 1'b0, 1'b0, 1'b0, 0, 0, sc, pr, lat, upd, rdy);
         n_checks += 5;
         if (rdy !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready[%0d] got=%b want=1", t, rdy); end
         if (lat != N) begin n_fail++; $display("FAIL basic_latency[%0d] got=%0d want=%0d", t, lat, N); end
         if (sc !== 16'(es[t])) begin n_fail++; $display("FAIL basic_score[%0d] got=%0d want=%0d", t, sc, es[t]); end
         if (pr !== ep[t]) begin n_fail++; $display("FAIL basic_predict[%0d] got=%b want=%b", t, pr, ep[t]); end
         if (upd != 0) begin n_fail++; $display("FAIL basic_busy_after[%0d] got=%0d want=0", t, upd); end
      end
   endtask

   task automatic test_train();
      logic signed [ACC-1:0] sc;
      logic                  pr;
      logic                  rdy;
      int                    lat;
      int                    upd;
      int                    rd;
      int                    ew [0:N];
      ew = '{2, -1, -1, 0, 1};
      run_vec(4'b0110, 1'b1, 1'b1, 1'b0, 0, 0, sc, pr, lat, upd, rdy);
      n_checks += 3;
      if (sc !== -16'sd4) begin n_fail++; $display("FAIL train_score got=%0d want=-4", sc); end
      if (pr !== 1'b0) begin n_fail++; $display("FAIL train_predict got=%b want=0", pr); end
      if (upd != N + 1) begin n_fail++; $display("FAIL train_busy_cycles got=%0d want=%0d", upd, N + 1); end
      for (int i = 0; i <= N; i++) begin
         read_w(i, rd);
         n_checks++;
         if (rd != ew[i]) begin n_fail++; $display("FAIL train_weight[%0d] got=%0d want=%0d", i, rd, ew[i]); end
         m_w[i] = ew[i];
      end
   endtask

   task automatic test_saturation();
      logic signed [ACC-1:0] sc;
      logic                  pr;
      logic                  rdy;
      int                    lat;
      int                    upd;
      int                    rd;
      write_w(0, 127);
      write_w(4, -128);
      run_vec(4'b0001, 1'b1, 1'b1, 1'b0, 0, 0, sc, pr, lat, upd, rdy);
      n_checks += 3;
      if (sc !== -16'sd1) begin n_fail++; $display("FAIL sat_score got=%0d want=-1", sc); end
      if (pr !== 1'b0) begin n_fail++; $display("FAIL sat_predict got=%b want=0", pr); end
      if (upd != N + 1) begin n_fail++; $display("FAIL sat_busy_cycles got=%0d want=%0d", upd, N + 1); end
      read_w(0, rd);
      n_checks++;
      if (rd != 127) begin n_fail++; $display("FAIL sat_w0 got=%0d want=127", rd); end
      read_w(4, rd);
      n_checks++;
      if (rd != -127) begin n_fail++; $display("FAIL sat_bias got=%0d want=-127", rd); end
      m_w[0] = 127;
      m_w[4] = -127;
   endtask

   task automatic test_backpressure();
      int   es;
      logic ep;
      int   eu;
      int   k;
      int   rd;
      model_run(4'b1111, 1'b0, 1'b0, es, ep, eu);
      in_valid = 1'b1;
      in_x     = 4'b1111;
      in_train = 1'b0;
      in_label = 1'b0;
      step();
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 50) begin
         step();
         k++;
      end
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_timeout got=%b want=1", out_valid); end
      for (int c = 0; c < 10; c++) begin
         if (c == 0) begin
            w_we    = 1'b1;
            w_addr  = 3'd0;
            w_wdata = 8'sd5;
         end else begin
            w_we    = 1'b0;
         end
         step();
         n_checks += 4;
         if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got=%b want=1", c, out_valid); end
         if (out_score !== 16'(es)) begin n_fail++; $display("FAIL bp_score[%0d] got=%0d want=%0d", c, out_score, es); end
         if (out_predict !== ep) begin n_fail++; $display("FAIL bp_predict[%0d] got=%b want=%b", c, out_predict, ep); end
         if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got=%b want=0", c, in_ready); end
      end
      w_we = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop got=%b want=0", out_valid); end
      read_w(0, rd);
      n_checks++;
      if (rd != m_w[0]) begin n_fail++; $display("FAIL bp_ignored_write got=%0d want=%0d", rd, m_w[0]); end
   endtask

   task automatic test_write_race();
      logic signed [ACC-1:0] sc;
      logic                  pr;
      logic                  rdy;
      int                    lat;
      int                    upd;
      int                    es;
      logic                  ep;
      int                    eu;
      m_w[4] = 10;
      model_run(4'b0001, 1'b0, 1'b0, es, ep, eu);
      run_vec(4'b0001, 1'b0, 1'b0, 1'b1, 4, 10, sc, pr, lat, upd, rdy);
      n_checks += 2;
      if (sc !== 16'(es)) begin n_fail++; $display("FAIL race_bias_score got=%0d want=%0d", sc, es); end
      if (pr !== ep) begin n_fail++; $display("FAIL race_bias_predict got=%b want=%b", pr, ep); end
      m_w[0] = -3;
      model_run(4'b0001, 1'b0, 1'b0, es, ep, eu);
      run_vec(4'b0001, 1'b0, 1'b0, 1'b1, 0, -3, sc, pr, lat, upd, rdy);
      n_checks += 2;
      if (sc !== 16'(es)) begin n_fail++; $display("FAIL race_w0_score got=%0d want=%0d", sc, es); end
      if (pr !== ep) begin n_fail++; $display("FAIL race_w0_predict got=%b want=%b", pr, ep); end
   endtask

   task automatic test_addr_range();
      int rd;
      w_we    = 1'b1;
      w_addr  = 3'd6;
      w_wdata = 8'sd55;
      step();
      w_we    = 1'b0;
      for (int a = N + 1; a < 8; a++) begin
         read_w(a, rd);
         n_checks++;
         if (rd != 0) begin n_fail++; $display("FAIL range_read[%0d] got=%0d want=0", a, rd); end
      end
      for (int i = 0; i <= N; i++) begin
         read_w(i, rd);
         n_checks++;
         if (rd != m_w[i]) begin n_fail++; $display("FAIL range_weight[%0d] got=%0d want=%0d", i, rd, m_w[i]); end
      end
   endtask

   task automatic test_random();
      logic signed [ACC-1:0] sc;
      logic                  pr;
      logic                  rdy;
      int                    lat;
      int                    upd;
      int                    es;
      logic                  ep;
      int                    eu;
      int                    rd;
      logic [N-1:0]          x;
      logic                  tr;
      logic                  lb;
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(2) == 0) begin
            write_w(int'($urandom_range(N)), int'($urandom_range(255)) - 128);
         end
         x  = N'($urandom_range(15));
         tr = 1'($urandom_range(1));
         lb = 1'($urandom_range(1));
         model_run(x, tr, lb, es, ep, eu);
         run_vec(x, tr, lb, 1'b0, 0, 0, sc, pr, lat, upd, rdy);
         n_checks += 4;
         if (lat != N) begin n_fail++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", t, lat, N); end
         if (sc !== 16'(es)) begin n_fail++; $display("FAIL rand_score[%0d] got=%0d want=%0d", t, sc, es); end
         if (pr !== ep) begin n_fail++; $display("FAIL rand_predict[%0d] got=%b want=%b", t, pr, ep); end
         if (upd != eu) begin n_fail++; $display("FAIL rand_update_cycles[%0d] got=%0d want=%0d", t, upd, eu); end
      end
      for (int i = 0; i <= N; i++) begin
         read_w(i, rd);
         n_checks++;
         if (rd != m_w[i]) begin n_fail++; $display("FAIL rand_weight[%0d] got=%0d want=%0d", i, rd, m_w[i]); end
      end
   endtask

   task automatic test_reset_mid();
      int rd;
      in_valid = 1'b1;
      in_x     = 4'b1111;
      in_train = 1'b1;
      in_label = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i <= N; i++) m_w[i] = 0;
      n_checks += 3;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b want=0", busy); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
      for (int i = 0; i <= N; i++) begin
         read_w(i, rd);
         n_checks++;
         if (rd != m_w[i]) begin n_fail++; $display("FAIL rstmid_weight[%0d] got=%0d want=%0d", i, rd, m_w[i]); end
      end
   endtask

   // Test sequence and final report.
   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_x      = '0;
      in_train  = 1'b0;
      in_label  = 1'b0;
      out_ready = 1'b0;
      w_we      = 1'b0;
      w_addr    = '0;
      w_wdata   = '0;
      test_reset();
      test_basic();
      test_train();
      test_saturation();
      test_backpressure();
      test_write_race();
      test_addr_range();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
